// File: rtl/game_countdown_timer.sv
// Countdown game clock: consumes the once-per-second pulse, keeps the remaining
// play time (M:SS BCD) and reports running / time-up / low-time warning status.
module game_countdown_timer #(
    parameter int START_SECONDS = 120,
    parameter int MAX_SECONDS   = 599,
    parameter int BONUS_SECONDS = 10,
    parameter int WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       secPassed,
    input  logic       startGame,
    input  logic       pause,
    input  logic       addBonus,
    output logic [3:0] minutes,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       running,
    output logic       timeUp,
    output logic       timeUpPulse,
    output logic       warning,
    output logic       blinkOn
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [9:0]  START_CNT = 10'(START_SECONDS);
    localparam logic [9:0]  MAX_CNT   = 10'(MAX_SECONDS);
    localparam logic [10:0] MAX_WIDE  = 11'(MAX_SECONDS);
    localparam logic [10:0] BONUS_INC = 11'(BONUS_SECONDS);
    localparam logic [9:0]  WARN_CNT  = 10'(WARN_SECONDS);

    state_t     state_reg, state_next;
    logic [9:0] count_reg, count_next;
    logic       running_reg;
    logic       time_up_reg;
    logic       time_up_pulse_reg, time_up_pulse_next;
    logic       warning_reg, warning_next;
    logic       blink_reg, blink_next;

    logic        tick_eff;
    logic [10:0] bonus_only_sum;
    logic [9:0]  bonus_only_sat;
    logic [10:0] tick_sum;
    logic [9:0]  tick_sat;

    // Both candidate updates are computed in 11 bits, then saturated at the ceiling.
    // The tick path never underflows: a RUNNING count is always at least 1.
    always_comb begin
        bonus_only_sum = {1'b0, count_reg} + BONUS_INC;
        bonus_only_sat = (bonus_only_sum > MAX_WIDE) ? MAX_CNT : bonus_only_sum[9:0];
        tick_sum       = {1'b0, count_reg} + (addBonus ? BONUS_INC : 11'd0) - 11'd1;
        tick_sat       = (tick_sum > MAX_WIDE) ? MAX_CNT : tick_sum[9:0];
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tick_eff   = 1'b0;

        if (startGame) begin
            count_next = START_CNT;
            state_next = pause ? PAUSED : RUNNING;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                RUNNING: begin
                    if (pause) begin
                        state_next = PAUSED;
                        if (addBonus) begin
                            count_next = bonus_only_sat;
                        end
                    end else if (secPassed) begin
                        tick_eff   = 1'b1;
                        count_next = tick_sat;
                        if (tick_sat == 10'd0) begin
                            state_next = EXPIRED;
                        end
                    end else if (addBonus) begin
                        count_next = bonus_only_sat;
                    end
                end
                PAUSED: begin
                    if (addBonus) begin
                        count_next = bonus_only_sat;
                    end
                    if (!pause) begin
                        state_next = RUNNING;
                    end
                end
                EXPIRED: begin
                    count_next = 10'd0;
                end
                default: begin
                    state_next = IDLE;
                    count_next = START_CNT;
                end
            endcase
        end
    end

    // Status flags are precomputed from the next state so they land together with it.
    always_comb begin
        warning_next = (count_next >= 10'd1) && (count_next <= WARN_CNT) &&
                       ((state_next == RUNNING) || (state_next == PAUSED));

        if (startGame || !warning_next) begin
            blink_next = 1'b1;
        end else if (tick_eff) begin
            blink_next = ~blink_reg;
        end else begin
            blink_next = blink_reg;
        end

        time_up_pulse_next = (state_next == EXPIRED) && (state_reg != EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            count_reg         <= START_CNT;
            running_reg       <= 1'b0;
            time_up_reg       <= 1'b0;
            time_up_pulse_reg <= 1'b0;
            warning_reg       <= 1'b0;
            blink_reg         <= 1'b1;
        end else begin
            state_reg         <= state_next;
            count_reg         <= count_next;
            running_reg       <= (state_next == RUNNING);
            time_up_reg       <= (state_next == EXPIRED);
            time_up_pulse_reg <= time_up_pulse_next;
            warning_reg       <= warning_next;
            blink_reg         <= blink_next;
        end
    end

    // BCD decode of the registered count (at most 599, so one minutes digit).
    logic [3:0] minutes_dec;
    logic [9:0] sec_in_min;

    always_comb begin
        minutes_dec = 4'(count_reg / 10'd60);
        sec_in_min  = count_reg - (10'(minutes_dec) * 10'd60);
    end

    assign minutes     = minutes_dec;
    assign secTens     = 4'(sec_in_min / 10'd10);
    assign secOnes     = 4'(count_reg % 10'd10);
    assign running     = running_reg;
    assign timeUp      = time_up_reg;
    assign timeUpPulse = time_up_pulse_reg;
    assign warning     = warning_reg;
    assign blinkOn     = blink_reg;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: directed scenarios with literal expectations,
// then random stimulus, all compared each cycle against a seconds-level model.
module tb_game_countdown_timer;

    localparam int START_S = 120;
    localparam int MAX_S   = 599;
    localparam int BONUS_S = 10;
    localparam int WARN_S  = 10;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       secPassed = 1'b0;
    logic       startGame = 1'b0;
    logic       pause = 1'b0;
    logic       addBonus = 1'b0;
    logic [3:0] minutes, secTens, secOnes;
    logic       running, timeUp, timeUpPulse, warning, blinkOn;

    int checks = 0;
    int errors = 0;
    bit checking_on = 1'b0;

    // Model of the game clock in plain seconds
    int m_count = START_S;
    int m_state = S_IDLE;
    bit m_blink = 1'b1;
    bit m_pulse = 1'b0;

    game_countdown_timer #(
        .START_SECONDS(START_S),
        .MAX_SECONDS  (MAX_S),
        .BONUS_SECONDS(BONUS_S),
        .WARN_SECONDS (WARN_S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .secPassed  (secPassed),
        .startGame  (startGame),
        .pause      (pause),
        .addBonus   (addBonus),
        .minutes    (minutes),
        .secTens    (secTens),
        .secOnes    (secOnes),
        .running    (running),
        .timeUp     (timeUp),
        .timeUpPulse(timeUpPulse),
        .warning    (warning),
        .blinkOn    (blinkOn)
    );

    always #5 clk = ~clk;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit model_warn();
        return (m_count >= 1) && (m_count <= WARN_S) &&
               ((m_state == S_RUN) || (m_state == S_PAUSE));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: one clock step from the sampled inputs
    always @(posedge clk) begin
        int prev;
        bit ticked;
        int delta;
        if (reset) begin
            m_count = START_S;
            m_state = S_IDLE;
            m_blink = 1'b1;
            m_pulse = 1'b0;
        end else begin
            prev   = m_state;
            ticked = 1'b0;
            if (startGame) begin
                m_count = START_S;
                m_state = pause ? S_PAUSE : S_RUN;
            end else if (m_state == S_RUN) begin
                if (pause) begin
                    m_state = S_PAUSE;
                    if (addBonus) m_count = min_i(m_count + BONUS_S, MAX_S);
                end else begin
                    delta  = (addBonus ? BONUS_S : 0) - (secPassed ? 1 : 0);
                    ticked = secPassed;
                    m_count = min_i(m_count + delta, MAX_S);
                    if (m_count <= 0) begin
                        m_count = 0;
                        m_state = S_EXP;
                    end
                end
            end else if (m_state == S_PAUSE) begin
                if (addBonus) m_count = min_i(m_count + BONUS_S, MAX_S);
                if (!pause) m_state = S_RUN;
            end
            if (startGame || !model_warn()) m_blink = 1'b1;
            else if (ticked) m_blink = !m_blink;
            m_pulse = (m_state == S_EXP) && (prev != S_EXP);
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (checking_on) begin
            check("minutes", int'(minutes), m_count / 60);
            check("secTens", int'(secTens), (m_count % 60) / 10);
            check("secOnes", int'(secOnes), m_count % 10);
            check("running", int'(running), int'(m_state == S_RUN));
            check("timeUp", int'(timeUp), int'(m_state == S_EXP));
            check("timeUpPulse", int'(timeUpPulse), int'(m_pulse));
            check("warning", int'(warning), int'(model_warn()));
            check("blinkOn", int'(blinkOn), int'(m_blink));
        end
    end

    // One clock of stimulus; returns at the following falling edge
    task automatic step(input bit sp, input bit sg, input bit pz, input bit ab);
        secPassed = sp;
        startGame = sg;
        pause     = pz;
        addBonus  = ab;
        @(negedge clk);
        secPassed = 1'b0;
        startGame = 1'b0;
        addBonus  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pin_time(input string name, input int m, input int t, input int o);
        check({name, ".min"}, int'(minutes), m);
        check({name, ".tens"}, int'(secTens), t);
        check({name, ".ones"}, int'(secOnes), o);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        checking_on = 1'b1;
        reset = 1'b0;
        pin_time("reset", 2, 0, 0);
        check("reset.running", int'(running), 0);
        check("reset.blink", int'(blinkOn), 1);

        // IDLE ignores ticks
        ticks(2);
        pin_time("idle_ignore", 2, 0, 0);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        pin_time("start", 2, 0, 0);
        check("start.running", int'(running), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); pin_time("tick1", 1, 5, 9);
        step(1'b1, 1'b0, 1'b0, 1'b0); pin_time("tick2", 1, 5, 8);
        step(1'b1, 1'b0, 1'b0, 1'b0); pin_time("tick3", 1, 5, 7);

        // Down to 11, then into the warning region
        ticks(106);
        pin_time("at11", 0, 1, 1);
        check("at11.warning", int'(warning), 0);
        ticks(1);
        check("at10.warning", int'(warning), 1);
        check("at10.blink", int'(blinkOn), 0);
        ticks(1);
        check("at9.blink", int'(blinkOn), 1);
        ticks(8);
        pin_time("at1", 0, 0, 1);
        ticks(1);
        pin_time("expire", 0, 0, 0);
        check("expire.timeUp", int'(timeUp), 1);
        check("expire.pulse", int'(timeUpPulse), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("expired.pulse_once", int'(timeUpPulse), 0);
        pin_time("expired_hold", 0, 0, 0);

        // Restart from EXPIRED with a coincident tick
        step(1'b1, 1'b1, 1'b0, 1'b0);
        pin_time("restart", 2, 0, 0);
        check("restart.timeUp", int'(timeUp), 0);
        check("restart.running", int'(running), 1);

        // Bonus rescues count 1
        ticks(119);
        pin_time("at1b", 0, 0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        pin_time("rescue", 0, 1, 0);
        check("rescue.running", int'(running), 1);
        check("rescue.timeUp", int'(timeUp), 0);

        // Pause freezes, bonus saturates, release resumes
        ticks(5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        pin_time("paused", 0, 0, 5);
        for (int i = 0; i < 59; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        pin_time("bonus595", 9, 5, 5);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pin_time("bonus_sat", 9, 5, 9);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pin_time("resume", 9, 5, 8);

        // Reset mid-run
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        pin_time("mid_reset", 2, 0, 0);
        check("mid_reset.running", int'(running), 0);
        check("mid_reset.pulse", int'(timeUpPulse), 0);

        // Randomized stimulus, model-checked every cycle
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            bit pz;
            pz = pause;
            if ($urandom_range(0, 29) == 0) pz = !pz;
            reset = ($urandom_range(0, 999) == 0);
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 299) == 0,
                 pz,
                 $urandom_range(0, 39) == 0);
            reset = 1'b0;
            if (!running && !pause && $urandom_range(0, 49) == 0)
                step(1'b0, 1'b1, 1'b0, 1'b0);
        end

        checking_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
